// File: rtl/timer_bcd_converter_pkg.sv
// Shared types and constants for the timer display path: the conversion
// state machine encoding, the BCD digit width and the double-dabble
// adjust rule used by every BCD nibble.
package timer_display_pkg;

  localparam int BCD_WIDTH            = 4;
  localparam int BCD_ADJUST_THRESHOLD = 5;
  localparam int BCD_ADJUST_ADD       = 3;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } conv_state_t;

  // A nibble that is 5 or more would overflow past 9 after the next shift,
  // so it is pre-biased by 3; the add stays inside the nibble.
  function automatic logic [BCD_WIDTH-1:0] bcd_adjust(input logic [BCD_WIDTH-1:0] nib);
    if (nib >= BCD_WIDTH'(BCD_ADJUST_THRESHOLD))
      bcd_adjust = nib + BCD_WIDTH'(BCD_ADJUST_ADD);
    else
      bcd_adjust = nib;
  endfunction

endpackage

// File: rtl/timer_bcd_converter_if.sv
// Bundle between game_timer (binary seconds/minutes) and the digit drawers
// (BCD digits plus status). The producer side drives the binary counts and
// the force request; the converter drives the digits and status.
interface timer_bcd_converter_if #(
  parameter int DIGIT_WIDTH = 6
);
  import timer_display_pkg::*;

  logic [DIGIT_WIDTH-1:0] seconds;
  logic [DIGIT_WIDTH-1:0] minutes;
  logic                   force_update;
  logic [BCD_WIDTH-1:0]   sec_ones;
  logic [BCD_WIDTH-1:0]   sec_tens;
  logic [BCD_WIDTH-1:0]   min_ones;
  logic [BCD_WIDTH-1:0]   min_tens;
  logic                   busy;
  logic                   digits_valid;

  modport master (
    output seconds, minutes, force_update,
    input  sec_ones, sec_tens, min_ones, min_tens, busy, digits_valid
  );

  modport slave (
    input  seconds, minutes, force_update,
    output sec_ones, sec_tens, min_ones, min_tens, busy, digits_valid
  );

endinterface

// File: rtl/timer_bcd_converter_step.sv
// One combinational double-dabble iteration on a {tens, ones, binary}
// vector: bias each BCD nibble that is 5 or more by 3, then shift the whole
// vector left by one so the next binary MSB enters the ones nibble.
module bcd_dabble_step
  import timer_display_pkg::*;
#(
  parameter int BIN_WIDTH = 6
) (
  input  logic [2*BCD_WIDTH+BIN_WIDTH-1:0] vec_in,
  output logic [2*BCD_WIDTH+BIN_WIDTH-1:0] vec_out
);

  localparam int VEC_WIDTH = 2*BCD_WIDTH + BIN_WIDTH;

  logic [VEC_WIDTH-1:0] adjusted;

  // Adjust both nibbles independently (no carry between them), then shift.
  always_comb begin
    adjusted = vec_in;
    adjusted[VEC_WIDTH-1 -: BCD_WIDTH] = bcd_adjust(vec_in[VEC_WIDTH-1 -: BCD_WIDTH]);
    adjusted[VEC_WIDTH-BCD_WIDTH-1 -: BCD_WIDTH] =
      bcd_adjust(vec_in[VEC_WIDTH-BCD_WIDTH-1 -: BCD_WIDTH]);
    vec_out = adjusted << 1;
  end

endmodule

// File: rtl/timer_bcd_converter.sv
// Converts the binary seconds/minutes counts from game_timer into two BCD
// digits each. A change on either input (or a force request while idle)
// snapshots both values and runs DIGIT_WIDTH double-dabble iterations in
// parallel; the finished digits are registered in one go so the display
// never sees intermediate values.
module timer_bcd_converter
  import timer_display_pkg::*;
#(
  parameter int DIGIT_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  resetN,
  timer_bcd_converter_if.slave  bus
);

  localparam int VEC_WIDTH = 2*BCD_WIDTH + DIGIT_WIDTH;
  localparam int CNT_WIDTH = $clog2(DIGIT_WIDTH + 1);

  conv_state_t state_q;
  conv_state_t state_d;

  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [DIGIT_WIDTH-1:0] last_sec_q;
  logic [DIGIT_WIDTH-1:0] last_min_q;
  logic [VEC_WIDTH-1:0]   sec_vec_q;
  logic [VEC_WIDTH-1:0]   min_vec_q;
  logic [VEC_WIDTH-1:0]   sec_vec_step;
  logic [VEC_WIDTH-1:0]   min_vec_step;
  logic [BCD_WIDTH-1:0]   sec_ones_q;
  logic [BCD_WIDTH-1:0]   sec_tens_q;
  logic [BCD_WIDTH-1:0]   min_ones_q;
  logic [BCD_WIDTH-1:0]   min_tens_q;
  logic                   digits_valid_q;
  logic                   start_req;

  // The snapshot in last_* doubles as the change detector, so an input that
  // moved during a conversion is picked up right after it finishes.
  assign start_req = (bus.seconds != last_sec_q) ||
                     (bus.minutes != last_min_q) ||
                     bus.force_update;

  bcd_dabble_step #(.BIN_WIDTH(DIGIT_WIDTH)) u_sec_step (
    .vec_in  (sec_vec_q),
    .vec_out (sec_vec_step)
  );

  bcd_dabble_step #(.BIN_WIDTH(DIGIT_WIDTH)) u_min_step (
    .vec_in  (min_vec_q),
    .vec_out (min_vec_step)
  );

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; force requests outside IDLE are simply not looked at.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_req) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_WIDTH'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Snapshot, shift registers and iteration counter.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q      <= '0;
      last_sec_q <= '0;
      last_min_q <= '0;
      sec_vec_q  <= '0;
      min_vec_q  <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          last_sec_q <= bus.seconds;
          last_min_q <= bus.minutes;
          sec_vec_q  <= {{(2*BCD_WIDTH){1'b0}}, bus.seconds};
          min_vec_q  <= {{(2*BCD_WIDTH){1'b0}}, bus.minutes};
          cnt_q      <= CNT_WIDTH'(DIGIT_WIDTH);
        end
        SHIFT: begin
          sec_vec_q <= sec_vec_step;
          min_vec_q <= min_vec_step;
          cnt_q     <= cnt_q - CNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  // Display registers only change on the DONE cycle, together with the pulse.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sec_ones_q     <= '0;
      sec_tens_q     <= '0;
      min_ones_q     <= '0;
      min_tens_q     <= '0;
      digits_valid_q <= 1'b0;
    end else begin
      digits_valid_q <= (state_q == DONE);
      if (state_q == DONE) begin
        sec_tens_q <= sec_vec_q[VEC_WIDTH-1 -: BCD_WIDTH];
        sec_ones_q <= sec_vec_q[VEC_WIDTH-BCD_WIDTH-1 -: BCD_WIDTH];
        min_tens_q <= min_vec_q[VEC_WIDTH-1 -: BCD_WIDTH];
        min_ones_q <= min_vec_q[VEC_WIDTH-BCD_WIDTH-1 -: BCD_WIDTH];
      end
    end
  end

  assign bus.sec_ones     = sec_ones_q;
  assign bus.sec_tens     = sec_tens_q;
  assign bus.min_ones     = min_ones_q;
  assign bus.min_tens     = min_tens_q;
  assign bus.digits_valid = digits_valid_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_timer_bcd_converter.sv
// Testbench for timer_bcd_converter: directed scenarios plus randomized
// input changes, compared every cycle against a behavioural model that
// works with plain decimal arithmetic and a conversion-latency countdown.
module tb_timer_bcd_converter;
  import timer_display_pkg::*;

  localparam int DW  = 6;
  localparam int LAT = DW + 2;

  logic clk = 1'b0;
  logic resetN;

  always #5 clk = ~clk;

  timer_bcd_converter_if #(.DIGIT_WIDTH(DW)) bus ();

  timer_bcd_converter #(.DIGIT_WIDTH(DW)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int checks_total  = 0;
  int checks_passed = 0;
  int valid_count   = 0;
  bit checking      = 0;

  // Reference model state: remaining cycles of the running conversion, the
  // snapshot it works on, and the digits the display should be showing.
  int m_busy_left = 0;
  int m_last_sec  = 0;
  int m_last_min  = 0;
  int m_sec_ones  = 0;
  int m_sec_tens  = 0;
  int m_min_ones  = 0;
  int m_min_tens  = 0;
  int m_valid     = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks_total++;
    if (observed == expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
  endtask

  // Model: a request accepted while idle takes LAT edges; the snapshot is
  // the input value one edge after acceptance; digits are value/10, value%10.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_busy_left = 0;
      m_last_sec  = 0;
      m_last_min  = 0;
      m_sec_ones  = 0;
      m_sec_tens  = 0;
      m_min_ones  = 0;
      m_min_tens  = 0;
      m_valid     = 0;
    end else begin
      m_valid = 0;
      if (m_busy_left == 0) begin
        if (int'(bus.seconds) != m_last_sec || int'(bus.minutes) != m_last_min ||
            bus.force_update)
          m_busy_left = LAT;
      end else begin
        if (m_busy_left == LAT) begin
          m_last_sec = int'(bus.seconds);
          m_last_min = int'(bus.minutes);
        end
        m_busy_left--;
        if (m_busy_left == 0) begin
          m_sec_tens = m_last_sec / 10;
          m_sec_ones = m_last_sec % 10;
          m_min_tens = m_last_min / 10;
          m_min_ones = m_last_min % 10;
          m_valid    = 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (checking) begin
      checkOutput("sec_ones", int'(bus.sec_ones), m_sec_ones);
      checkOutput("sec_tens", int'(bus.sec_tens), m_sec_tens);
      checkOutput("min_ones", int'(bus.min_ones), m_min_ones);
      checkOutput("min_tens", int'(bus.min_tens), m_min_tens);
      checkOutput("busy", int'(bus.busy), int'(m_busy_left != 0));
      checkOutput("digits_valid", int'(bus.digits_valid), m_valid);
    end
  end

  // Pulse counter, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (bus.digits_valid) valid_count++;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge: drive inputs, hold force for one cycle, wait n cycles.
  task automatic applyStimulus(input int sec, input int min, input bit force_up, input int n);
    bus.seconds      = DW'(sec);
    bus.minutes      = DW'(min);
    bus.force_update = force_up;
    @(negedge clk);
    bus.force_update = 1'b0;
    if (n > 1) waitCycles(n - 1);
  endtask

  task automatic checkDigits(input string tag, input int mt, input int mo, input int st, input int so);
    checkOutput({tag, "_min_tens"}, int'(bus.min_tens), mt);
    checkOutput({tag, "_min_ones"}, int'(bus.min_ones), mo);
    checkOutput({tag, "_sec_tens"}, int'(bus.sec_tens), st);
    checkOutput({tag, "_sec_ones"}, int'(bus.sec_ones), so);
  endtask

  initial begin
    int base;
    resetN           = 1'b0;
    bus.seconds      = '0;
    bus.minutes      = '0;
    bus.force_update = 1'b0;
    waitCycles(3);
    resetN   = 1'b1;
    checking = 1;

    // Reset state and a quiet 0:00 input.
    checkDigits("reset", 0, 0, 0, 0);
    base = valid_count;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("idle_busy", int'(bus.busy), 0);
    end
    checkOutput("idle_pulses", valid_count - base, 0);

    // 0:00 -> 0:37 with exact latency and held outputs.
    $display("[TB] seconds 0 -> 37");
    base = valid_count;
    applyStimulus(37, 0, 0, 1);
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) begin
        checkOutput("lat_busy", int'(bus.busy), 1);
        checkOutput("lat_valid", int'(bus.digits_valid), 0);
        checkDigits("lat_hold", 0, 0, 0, 0);
      end else begin
        checkOutput("lat_busy_end", int'(bus.busy), 0);
        checkOutput("lat_valid_end", int'(bus.digits_valid), 1);
        checkDigits("lat_37", 0, 0, 3, 7);
      end
      if (k < 9) @(negedge clk);
    end
    waitCycles(3);
    checkOutput("lat_pulses", valid_count - base, 1);

    // 1:59 then 2:00: one conversion covers both fields.
    $display("[TB] 1:59 -> 2:00");
    applyStimulus(59, 1, 0, 12);
    checkDigits("t159", 0, 1, 5, 9);
    base = valid_count;
    applyStimulus(0, 2, 0, 12);
    checkOutput("rollover_pulses", valid_count - base, 1);
    checkDigits("t200", 0, 2, 0, 0);

    // Input changes mid-conversion: back-to-back conversions, 9 cycles apart.
    $display("[TB] change while busy");
    applyStimulus(5, 2, 0, 1);
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) bus.seconds = DW'(9);
      checkOutput("b2b_valid", int'(bus.digits_valid), int'(k == 9 || k == 9 + DW + 3));
      if (k == 9) checkOutput("b2b_first", int'(bus.sec_ones), 5);
      if (k == 9 + DW + 3) checkOutput("b2b_second", int'(bus.sec_ones), 9);
      @(negedge clk);
    end

    // force_update with stable inputs; a second force while busy is dropped.
    $display("[TB] force_update at 63:45");
    applyStimulus(45, 63, 0, 12);
    base = valid_count;
    applyStimulus(45, 63, 1, 3);
    checkOutput("force_busy", int'(bus.busy), 1);
    bus.force_update = 1'b1;
    @(negedge clk);
    bus.force_update = 1'b0;
    waitCycles(12);
    checkOutput("force_pulses", valid_count - base, 1);
    checkDigits("t6345", 6, 3, 4, 5);

    // Reset during SHIFT clears the display asynchronously.
    $display("[TB] reset mid-conversion");
    applyStimulus(34, 12, 0, 4);
    #2;
    resetN = 1'b0;
    #1;
    checkDigits("async_rst", 0, 0, 0, 0);
    checkOutput("async_rst_busy", int'(bus.busy), 0);
    checkOutput("async_rst_valid", int'(bus.digits_valid), 0);
    waitCycles(2);
    resetN = 1'b1;
    base = valid_count;
    waitCycles(12);
    checkOutput("post_rst_pulses", valid_count - base, 1);
    checkDigits("t1234", 1, 2, 3, 4);

    // Randomized input changes and force requests.
    $display("[TB] random phase");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(int'($urandom_range(59, 0)), int'($urandom_range(63, 0)),
                    ($urandom_range(7, 0) == 0), int'($urandom_range(12, 1)));
    end
    waitCycles(2 * LAT + 4);

    checking = 0;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
